// File: rtl/div_6by3_seq.sv
// Restoring divider, one quotient bit per clock; DW-cycle latency, 1 cycle for divide-by-zero.
// No backpressure: start is only sampled in IDLE and ignored while busy; done is a one-cycle pulse.
module div_6by3_seq #(
    parameter int DW = 6,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_zero
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t        state;
    logic [DW-1:0] dvd_sh;
    logic [VW-1:0] dvs;
    logic [VW:0]   prem;
    logic [CW-1:0] cnt;
    logic          dz_pend;

    logic [VW:0]   shifted;
    logic [VW:0]   trial;
    logic          fits;
    logic [VW:0]   prem_nxt;
    logic [DW-1:0] dvd_nxt;

    // The dividend register doubles as the quotient: MSB shifts out, quotient bit shifts in.
    always_comb begin
        shifted  = {prem[VW-1:0], dvd_sh[DW-1]};
        trial    = shifted - {1'b0, dvs};
        fits     = (shifted >= {1'b0, dvs});
        prem_nxt = fits ? trial : shifted;
        dvd_nxt  = {dvd_sh[DW-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dvd_sh    <= '0;
            dvs       <= '0;
            prem      <= '0;
            cnt       <= '0;
            dz_pend   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done    <= 1'b0;
            dz_pend <= 1'b0;
            // Divide-by-zero result lands one edge after acceptance, FSM never leaves IDLE.
            if (dz_pend) begin
                quotient  <= '1;
                remainder <= '0;
                div_zero  <= 1'b1;
                done      <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dvd_sh <= dividend;
                            dvs    <= divisor;
                            prem   <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else begin
                            dz_pend <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    prem   <= prem_nxt;
                    dvd_sh <= dvd_nxt;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        quotient  <= dvd_nxt;
                        remainder <= prem_nxt[VW-1:0];
                        div_zero  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_6by3_seq.sv
// Randomised scoreboard bench for div_6by3_seq against a plain-arithmetic reference.
module tb_div_6by3_seq;
    localparam int DW = 6;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_zero;

    div_6by3_seq #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int at;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int k);
        exp_t m;
        m.a = a;
        m.b = b;
        if (b == 0) begin
            m.q = (1 << DW) - 1; m.r = 0; m.dz = 1; m.at = k + 1;
        end else begin
            m.q = a / b; m.r = a % b; m.dz = 0; m.at = k + DW;
        end
        return m;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done at cycle %0d: got q=%0d r=%0d, expected no done", cyc, quotient, remainder);
            end else begin
                e = sbq.pop_front();
                check("quotient", int'(quotient), e.q);
                check("remainder", int'(remainder), e.r);
                check("div_zero", int'(div_zero), e.dz);
                check("done_cycle", cyc, e.at);
                check("busy_at_done", int'(busy), 0);
                if (e.b != 0) begin
                    check("identity", int'(quotient) * e.b + int'(remainder), e.a);
                    check("rem_lt_div", int'(int'(remainder) < e.b), 1);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen, so the next call is back-to-back.
    task automatic run_op(input int a, input int b, input int spur);
        int k;
        int bc;
        bit seen;
        dividend = DW'(a);
        divisor  = VW'(b);
        start    = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        sbq.push_back(model(a, b, k));
        @(negedge clk);
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        bc   = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                bc += int'(busy);
                if (n == spur) begin
                    start = 1'b1; dividend = 7; divisor = 1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        check("busy_cycles", bc, (b == 0) ? 0 : DW);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_quotient"}, int'(quotient), 0);
        check({tag, "_remainder"}, int'(remainder), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_div_zero"}, int'(div_zero), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(63, 7, -1);
        run_op(45, 4, -1);
        run_op(5, 7, -1);
        run_op(20, 0, -1);
        run_op(12, 3, -1);
        run_op(50, 6, 3);

        // Abort an operation mid-flight; outputs must clear without waiting for an edge.
        dividend = 63; divisor = 5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_before_abort", int'(busy), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(10, 3, -1);

        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 8; b++)
                run_op(a, b, -1);

        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = $urandom_range(2);
            repeat (gap) @(negedge clk);
            run_op($urandom_range(63), $urandom_range(7), -1);
        end

        repeat (12) @(negedge clk);
        check("queue_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/div_6by3_seq.md
# div_6by3_seq

Sequential restoring divider: inverse of the 3x3 multiplier. Takes a 6-bit dividend (the multiplier's product width) and a 3-bit divisor, and returns a 6-bit quotient and 3-bit remainder. Produces one quotient bit per clock under a start/done handshake. Used to decompose products back into their factors and as the self-check partner for the multiplier datapath.

## Interface

**Parameters**
- `DW`, 6: dividend and quotient width.
- `VW`, 3: divisor and remainder width.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a division; sampled only in IDLE.
- `dividend`, input, DW: numerator; captured on the accepting edge.
- `divisor`, input, VW: denominator; captured on the accepting edge.
- `quotient`, output, DW: result quotient; held until the next result.
- `remainder`, output, VW: result remainder; held until the next result.
- `busy`, output, 1: high while a division is in progress.
- `done`, output, 1: one-cycle pulse when `quotient`/`remainder` are updated.
- `div_zero`, output, 1: set with `done` when divisor was 0; held with the result.

## Operation

**States:** IDLE, CALC.

**IDLE**
- If `start` = 1 and the captured divisor ≠ 0: latch the dividend into a shift register and the divisor into a register. Clear the partial remainder (VW+1 bits) and the bit counter. Go to CALC; `busy` = 1.
- If `start` = 1 and divisor = 0: stay in IDLE. Next edge drives `quotient` = all ones (63), `remainder` = 0, `div_zero` = 1, `done` = 1. `busy` never rises.

**CALC** (restoring algorithm, one iteration per edge, DW iterations)
- Shift the partial remainder left by 1, bringing in the dividend MSB.
- Trial-subtract the divisor, zero-extended to VW+1 bits.
- If the result is non-negative: keep the difference and shift in quotient bit 1. Otherwise restore the remainder and shift in 0.
- After iteration DW: load `quotient`, `remainder` (low VW bits of the partial remainder; always < divisor), `div_zero` = 0, `done` = 1, `busy` = 0. Return to IDLE.

**Handshake and control**
- `start` while `busy` = 1 is ignored; the in-flight operation is unaffected.
- `start` in the cycle `done` = 1 is accepted, because the FSM is already in IDLE. Back-to-back operations are legal.
- Inputs are only sampled at acceptance. Changing `dividend`/`divisor` during CALC has no effect.

**Arithmetic**
- Result always satisfies `quotient` × `divisor` + `remainder` = `dividend`, with `remainder` < `divisor`, for divisor 1..7.
- Quotient never overflows DW bits.

**Reset** (`rst_n` low, any time, including mid-CALC)
- Asynchronously forces IDLE and aborts any operation.
- `quotient` = 0, `remainder` = 0, `busy` = 0, `done` = 0, `div_zero` = 0. Internal registers and counter are cleared.
- After release, the first `start` behaves normally.

## Timing

- Accept edge = edge k (`start` = 1 sampled in IDLE).
- Nonzero divisor: `busy` = 1 from after edge k to edge k+DW. `done` = 1 and the result is valid after edge k+DW. Latency is DW = 6 cycles. `done` drops after edge k+DW+1 unless a new operation completes then.
- Zero divisor: `done`/`div_zero` are valid after edge k+1; latency 1.
- Max throughput: one division per DW cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan

- **Nominal:** reset, then `start` with 63 / 7. Required: `busy` high 6 cycles, `done` after edge k+6, `quotient` = 9, `remainder` = 0, `div_zero` = 0.
- **Remainder and small dividend:** 45 / 4 gives `quotient` = 11, `remainder` = 1. Then 5 / 7 started in the `done` cycle gives `quotient` = 0, `remainder` = 5, with `done` exactly 6 cycles later.
- **Divide by zero:** 20 / 0 gives `done` and `div_zero` = 1 after edge k+1, `quotient` = 63, `remainder` = 0, `busy` never high. A following 12 / 3 gives `quotient` = 4, `remainder` = 0, `div_zero` = 0.
- **Ignored start:** start 50 / 6, then pulse `start` with 7 / 1 at cycle 3. Required: single `done` at k+6 with `quotient` = 8, `remainder` = 2; no second `done`.
- **Reset mid-operation:** start 63 / 5, drop `rst_n` at cycle 3. Required: all outputs 0 immediately (asynchronous). After release, 10 / 3 gives `quotient` = 3, `remainder` = 1.
- **Exhaustive:** all dividend 0..63 × divisor 1..7, compared against the multiplier. Required: `quotient` × `divisor` + `remainder` == `dividend` and `remainder` < `divisor` for all 448 cases; divisor 0 always flags `div_zero`.
